// File: rtl/rf_multiport_dump.sv
// rf_multiport_dump
//   Parametrised register file for the decode stage: NUM_RD registered read
//   ports, one write port, optional hardwired-zero R0, optional write-to-read
//   bypass, and a dump engine that streams every register out over a
//   valid/ready port when the core's halt level rises.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   rd_en   [NUM_RD]      per-port read enable (rd_data holds when low)
//   rd_addr [NUM_RD*AW]   packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data [NUM_RD*DW]   packed registered read data, same packing
//   wr_en, wr_addr, wr_data   single write port
//   hlt                   halt level; a rising edge starts a dump
//   dump_valid/dump_ready handshake for the dump stream
//   dump_idx, dump_data   index and contents of the current dump word
//   dump_done             one-cycle pulse after the last word is accepted
//   busy                  high while the dump engine is not idle
module rf_multiport_dump #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned NUM_RD  = 2,
  parameter int unsigned ZERO_R0 = 1,
  parameter int unsigned BYPASS  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     hlt,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [ADDR_W-1:0]        dump_idx,
  output logic [DATA_W-1:0]        dump_data,
  output logic                     dump_done,
  output logic                     busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;

  // With a hardwired R0, writes to address 0 are simply discarded.
  assign wr_ok = wr_en && !((ZERO_R0 != 0) && (wr_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read ports: each port is an independent registered lookup.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] val;
    logic [DATA_W-1:0] q;

    assign ra = rd_addr[k*ADDR_W +: ADDR_W];

    // Zero register wins over bypass so R0 always reads 0 when hardwired.
    always_comb begin
      if ((ZERO_R0 != 0) && (ra == '0)) begin
        val = '0;
      end else if ((BYPASS != 0) && wr_en && (wr_addr == ra)) begin
        val = wr_data;
      end else begin
        val = mem[ra];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
      end else if (rd_en[k]) begin
        q <= val;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = q;
  end

  // Dump engine.
  state_t state;
  logic   hlt_q;
  logic   rise;

  assign rise = hlt & ~hlt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hlt_q      <= 1'b0;
      dump_idx   <= '0;
      dump_valid <= 1'b0;
      dump_done  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      hlt_q <= hlt;
      case (state)
        IDLE: begin
          dump_done <= 1'b0;
          if (rise) begin
            state      <= DUMP;
            dump_idx   <= '0;
            dump_valid <= 1'b1;
            busy       <= 1'b1;
          end
        end
        DUMP: begin
          if (dump_ready) begin
            // Last index leaves dump_idx parked at DEPTH-1; DONE resets it.
            if (dump_idx == '1) begin
              state      <= DONE;
              dump_valid <= 1'b0;
              dump_done  <= 1'b1;
            end else begin
              dump_idx <= dump_idx + 1'b1;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          dump_done <= 1'b0;
          busy      <= 1'b0;
          dump_idx  <= '0;
        end
        default: begin
          state      <= IDLE;
          dump_idx   <= '0;
          dump_valid <= 1'b0;
          dump_done  <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  // Unregistered view of the array: the word handed over is the content
  // before any write landing on the same edge.
  always_comb begin
    if ((ZERO_R0 != 0) && (dump_idx == '0)) begin
      dump_data = '0;
    end else begin
      dump_data = mem[dump_idx];
    end
  end

endmodule

// File: doc/rf_multiport_dump.md
Name: rf_multiport_dump

Overview:
- Parametrised successor to the single-issue triple-ported register file.
- Provides DATA_W x 2**ADDR_W storage, NUM_RD registered read ports, one write port, optional hardwired-zero R0 and optional write-to-read bypass.
- Replaces the simulation-only halt dump with a synthesisable dump engine. On a halt rising edge it streams every register out over a valid/ready port.
- Sits in the decode stage of the pipelined core; the dump port feeds the debug/trace unit.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_R0, 1, 1 = register 0 reads 0 and ignores writes.
- BYPASS, 1, 1 = same-cycle write data forwarded to a matching read.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_en  in  NUM_RD  per-port read enable.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed registered read data, same packing.
- wr_en  in  1  write enable.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- hlt  in  1  halt level from core; rising edge starts dump.
- dump_valid  out  1  dump word valid.
- dump_ready  in  1  consumer accepts dump word.
- dump_idx  out  ADDR_W  register index of current dump word.
- dump_data  out  DATA_W  contents of register dump_idx.
- dump_done  out  1  one-cycle pulse after last word accepted.
- busy  out  1  high while dump FSM not IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all DEPTH registers cleared to 0;
  - rd_data = 0; hlt_q = 0;
  - FSM = IDLE, dump_idx = 0, dump_valid = 0, dump_done = 0, busy = 0.
- Write: at posedge, if wr_en, mem[wr_addr] <= wr_data. When ZERO_R0 = 1, a write with wr_addr = 0 is dropped.
- Read, per port k:
  - At posedge with rd_en[k] = 1, rd_data[k] is loaded; with rd_en[k] = 0 it holds its previous value.
  - Latency is 1 cycle: address presented in cycle N, data visible after edge N.
  - Load value, in priority order:
    1. 0 if ZERO_R0 = 1 and addr = 0;
    2. otherwise wr_data if BYPASS = 1 and wr_en = 1 and wr_addr = rd_addr[k];
    3. otherwise mem[rd_addr[k]] (the pre-write value).
  - All ports are independent; any number may read the same address.
- Halt edge detect: hlt_q <= hlt each cycle; rise = hlt & ~hlt_q.
- Dump FSM:
  - IDLE: busy = 0, dump_valid = 0. On rise: go to DUMP with dump_idx = 0.
  - DUMP: busy = 1, dump_valid = 1, dump_data = current mem[dump_idx] (0 for index 0 when ZERO_R0 = 1).
    - On dump_valid & dump_ready: if dump_idx = DEPTH-1, go to DONE; else dump_idx += 1.
    - If dump_ready is low, dump_idx and dump_valid hold.
  - DONE: dump_done = 1 for exactly one cycle, dump_idx <- 0, then IDLE.
- Boundary conditions:
  - rise while busy is ignored; hlt held high does not retrigger.
  - A new rise after return to IDLE starts a fresh dump.
  - Writes remain legal during a dump. dump_data reflects the register contents at the moment of the handshake; a write to dump_idx in the same cycle shows the old value.
  - Read ports remain fully functional during a dump.
  - rst_n asserted mid-dump aborts immediately: no dump_done pulse, registers cleared.
  - dump_idx wraps only through DONE; it never increments past DEPTH-1.

Test Plan:
- Reset then read all 16 addresses on both ports -> rd_data = 0x0000 one cycle after each request; busy = 0.
- Write R3 = 0xBEEF, next cycle read R3 on port0 -> port0 = 0xBEEF after 1 cycle. Same-cycle write R5 = 0x1234 with read R5 -> 0x1234 when BYPASS = 1, old value 0x0000 when BYPASS = 0.
- Write R0 = 0xFFFF, then read R0 -> 0x0000 (ZERO_R0 = 1). With ZERO_R0 = 0 -> 0xFFFF.
- Load Rn = 0x1000+n for n = 1..15, pulse hlt, dump_ready held 1 -> 16 consecutive valid words, idx 0..15, data 0x0000, 0x1001..0x100F; dump_done pulses the cycle after idx 15 is accepted; busy then drops.
- Same as above with dump_ready toggling 1,0,0,1 -> idx/data stable while stalled, no word lost or duplicated. A second hlt rise during the dump is ignored; exactly one dump_done.
- Drop rst_n at dump_idx = 7 -> dump_valid, busy and dump_idx = 0 immediately, no dump_done, all registers read 0 afterwards. Repeat with NUM_RD = 4, DATA_W = 32, ADDR_W = 5 for a 32-word dump.
